// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the iterative
// RV32M multiply/divide unit (slave).
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            START;
  logic            FLUSH;
  logic [2:0]      OP;
  logic [XLEN-1:0] OPERAND_A;
  logic [XLEN-1:0] OPERAND_B;
  logic [4:0]      RD_ADDR_IN;
  logic            BUSY;
  logic            DONE;
  logic [XLEN-1:0] RESULT;
  logic [4:0]      RD_ADDR_OUT;

  modport master (
    output START, FLUSH, OP, OPERAND_A, OPERAND_B, RD_ADDR_IN,
    input  BUSY, DONE, RESULT, RD_ADDR_OUT
  );

  modport slave (
    input  START, FLUSH, OP, OPERAND_A, OPERAND_B, RD_ADDR_IN,
    output BUSY, DONE, RESULT, RD_ADDR_OUT
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on
// operand magnitudes, UNROLL bits per CALC cycle, START/BUSY/DONE handshake with FLUSH abort.
module muldiv_unit #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic         CLK,
  input  logic         RESET,
  muldiv_unit_if.slave bus
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MUL  = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
    OP_DIV  = 3'b100, OP_DIVU = 3'b101, OP_REM    = 3'b110, OP_REMU  = 3'b111
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q;
  logic [CW-1:0]     count_q;
  op_e               op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  // a_q: multiplier (shifts right) or dividend becoming quotient (shifts left).
  // b_q: multiplicand (shifts left) or divisor in the low half.
  // acc_q: product, or partial remainder in the low XLEN+1 bits.
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] b_q;
  logic [2*XLEN-1:0] acc_q;
  logic              busy_q, done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        rd_out_q;

  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.RESULT      = result_q;
  assign bus.RD_ADDR_OUT = rd_out_q;

  // Accept-time decode of signedness, magnitudes and the RISC-V special cases.
  op_e             op_in;
  logic            in_div, in_rem, neg_a, neg_b, div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_result;

  always_comb begin
    op_in    = op_e'(bus.OP);
    in_div   = bus.OP[2];
    in_rem   = bus.OP[2] & bus.OP[1];
    neg_a    = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) & bus.OPERAND_A[XLEN-1];
    neg_b    = (op_in inside {OP_MULH, OP_DIV, OP_REM}) & bus.OPERAND_B[XLEN-1];
    mag_a    = neg_a ? -bus.OPERAND_A : bus.OPERAND_A;
    mag_b    = neg_b ? -bus.OPERAND_B : bus.OPERAND_B;
    div_zero = in_div && (bus.OPERAND_B == '0);
    div_ovf  = in_div && !bus.OP[0] && (bus.OPERAND_A == INT_MIN) && (bus.OPERAND_B == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_result = in_rem ? bus.OPERAND_A : '1;
    else          fast_result = in_rem ? '0 : bus.OPERAND_A;
  end

  logic              calc_div;
  logic [2*XLEN-1:0] prod_nx, mcand_nx, prod_fix;
  logic [XLEN-1:0]   a_nx, quo_fix, rem_fix, calc_result;
  logic [XLEN:0]     rem_nx;

  assign calc_div = op_q[2];

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    prod_nx  = acc_q;
    mcand_nx = b_q;
    a_nx     = a_q;
    rem_nx   = acc_q[XLEN:0];
    for (int j = 0; j < UNROLL; j++) begin
      if (calc_div) begin
        rem_nx = {rem_nx[XLEN-1:0], a_nx[XLEN-1]};
        a_nx   = a_nx << 1;
        if (rem_nx >= {1'b0, b_q[XLEN-1:0]}) begin
          rem_nx  = rem_nx - {1'b0, b_q[XLEN-1:0]};
          a_nx[0] = 1'b1;
        end
      end else begin
        if (a_nx[0]) prod_nx = prod_nx + mcand_nx;
        mcand_nx = mcand_nx << 1;
        a_nx     = a_nx >> 1;
      end
    end
    prod_fix = neg_q ? -prod_nx : prod_nx;
    quo_fix  = neg_q ? -a_nx : a_nx;
    rem_fix  = neg_q ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];
    case (op_q)
      OP_MUL:                       calc_result = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_result = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_result = quo_fix;
      default:                      calc_result = rem_fix;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= OP_MUL;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.FLUSH) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_CALC: begin
            acc_q   <= calc_div ? {{(XLEN-1){1'b0}}, rem_nx} : prod_nx;
            a_q     <= a_nx;
            b_q     <= mcand_nx;
            count_q <= count_q + CW'(1);
            if (count_q == CW'(N - 1)) begin
              state_q  <= S_DONE;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              result_q <= calc_result;
              rd_out_q <= rd_q;
            end
          end
          default: begin
            // IDLE and DONE both accept a new request, giving back-to-back issue.
            state_q <= S_IDLE;
            if (bus.START) begin
              op_q    <= op_in;
              rd_q    <= bus.RD_ADDR_IN;
              neg_q   <= in_rem ? neg_a : (neg_a ^ neg_b);
              count_q <= '0;
              acc_q   <= '0;
              a_q     <= in_div ? mag_a : mag_b;
              b_q     <= {{XLEN{1'b0}}, (in_div ? mag_b : mag_a)};
              if (fast) begin
                state_q  <= S_DONE;
                done_q   <= 1'b1;
                result_q <= fast_result;
                rd_out_q <= bus.RD_ADDR_IN;
              end else begin
                state_q <= S_CALC;
                busy_q  <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end
endmodule
